// File: rtl/ldpc_route_scheduler.sv
// Route-table walker for the LDPC mux trees: issues one route command per cycle,
// layer by layer, and inserts a pipeline drain gap between layers.
//
// state | meaning
// IDLE  | waiting for i_start; route table writable
// FETCH | table read of ptr in flight
// ISSUE | route command presented, advances on i_ready
// DRAIN | mux-tree pipeline drain after a layer end
// DONE  | one-cycle completion pulse
module ldpc_route_scheduler #(
   parameter int NUM_RAMS         = 24,
   parameter int NUM_BRANCHES     = 8,
   parameter int EXPANSION_FACTOR = 96,
   parameter int MAX_ENTRIES      = 256,
   parameter int MUX_LATENCY      = 5,
   parameter int MAX_ITERS        = 31,
   localparam int RW  = $clog2(NUM_RAMS),
   localparam int BW  = $clog2(NUM_BRANCHES),
   localparam int SW  = $clog2(EXPANSION_FACTOR),
   localparam int AW  = $clog2(MAX_ENTRIES),
   localparam int IW  = $clog2(MAX_ITERS + 1),
   localparam int DW  = RW + BW + SW + 1
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_cfg_we,
   input  logic [AW-1:0] i_cfg_addr,
   input  logic [DW-1:0] i_cfg_data,
   input  logic [AW:0]   i_num_entries,
   input  logic [IW-1:0] i_num_iters,
   input  logic          i_start,
   output logic [RW-1:0] o_ram_addr,
   output logic [BW-1:0] o_to_branch,
   output logic [SW-1:0] o_shift,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_layer_end,
   output logic [IW-1:0] o_iter,
   output logic          o_busy,
   output logic          o_done
);

   localparam int DCW = $clog2(MUX_LATENCY + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] iter_q, iter_d;
   logic [AW:0]   num_entries_q, num_entries_d;
   logic [IW-1:0] num_iters_q, num_iters_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic          iter_end_q, iter_end_d;
   logic          fresh_q, fresh_d;
   logic [DW-1:0] hold_q, hold_d;

   logic [DW-1:0] table_mem [MAX_ENTRIES];
   logic [DW-1:0] rd_data_q;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] cur_entry;
   logic          at_end;
   logic [IW-1:0] iter_inc;

   // The read port runs one entry ahead during ISSUE, so a stalled command is
   // served from hold_q rather than from the (already advanced) read data.
   assign cur_entry = fresh_q ? rd_data_q : hold_q;
   assign at_end    = ({1'b0, ptr_q} == (num_entries_q - {{AW{1'b0}}, 1'b1}));
   assign iter_inc  = iter_q + IW'(1);

   always_ff @(posedge i_clock) begin
      if (i_cfg_we && !o_busy) begin
         table_mem[i_cfg_addr] <= i_cfg_data;
      end
      rd_data_q <= table_mem[rd_addr];
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      iter_d        = iter_q;
      num_entries_d = num_entries_q;
      num_iters_d   = num_iters_q;
      drain_d       = drain_q;
      iter_end_d    = iter_end_q;
      hold_d        = hold_q;
      fresh_d       = 1'b0;
      rd_addr       = ptr_q + AW'(1);
      o_valid       = 1'b0;
      o_layer_end   = 1'b0;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      case (state_q)
         S_IDLE: begin
            rd_addr = ptr_q;
            if (i_start) begin
               o_busy        = 1'b1;
               num_entries_d = i_num_entries;
               num_iters_d   = i_num_iters;
               ptr_d         = '0;
               iter_d        = '0;
               if ((i_num_entries == '0) || (i_num_iters == '0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            o_busy  = 1'b1;
            rd_addr = ptr_q;
            fresh_d = 1'b1;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            o_busy  = 1'b1;
            o_valid = 1'b1;
            hold_d  = cur_entry;
            if (i_ready) begin
               if (cur_entry[0] || at_end) begin
                  o_layer_end = 1'b1;
                  drain_d     = DCW'(MUX_LATENCY);
                  iter_end_d  = at_end;
                  state_d     = S_DRAIN;
               end else begin
                  ptr_d   = ptr_q + AW'(1);
                  fresh_d = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            o_busy = 1'b1;
            if (drain_q == DCW'(1)) begin
               if (iter_end_q) begin
                  ptr_d   = '0;
                  iter_d  = iter_inc;
                  state_d = (iter_inc == num_iters_q) ? S_DONE : S_FETCH;
               end else begin
                  ptr_d   = ptr_q + AW'(1);
                  state_d = S_FETCH;
               end
            end else begin
               drain_d = drain_q - DCW'(1);
            end
         end
         S_DONE: begin
            o_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         iter_q        <= '0;
         num_entries_q <= '0;
         num_iters_q   <= '0;
         drain_q       <= '0;
         iter_end_q    <= 1'b0;
         fresh_q       <= 1'b0;
         hold_q        <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         iter_q        <= iter_d;
         num_entries_q <= num_entries_d;
         num_iters_q   <= num_iters_d;
         drain_q       <= drain_d;
         iter_end_q    <= iter_end_d;
         fresh_q       <= fresh_d;
         hold_q        <= hold_d;
      end
   end

   assign o_ram_addr  = o_valid ? cur_entry[DW-1 -: RW]  : '0;
   assign o_to_branch = o_valid ? cur_entry[SW+1 +: BW]  : '0;
   assign o_shift     = o_valid ? cur_entry[1 +: SW]     : '0;
   assign o_iter      = iter_q;

endmodule

// File: tb/tb_ldpc_route_scheduler.sv
// Scoreboard bench for ldpc_route_scheduler: stimulus pushes expected route
// commands, a negedge monitor pops and compares them on every transfer.
module tb_ldpc_route_scheduler;

   localparam int MUX_LAT = 5;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_cfg_we;
   logic [7:0]  i_cfg_addr;
   logic [15:0] i_cfg_data;
   logic [8:0]  i_num_entries;
   logic [4:0]  i_num_iters;
   logic        i_start;
   logic [4:0]  o_ram_addr;
   logic [2:0]  o_to_branch;
   logic [6:0]  o_shift;
   logic        o_valid;
   logic        i_ready;
   logic        o_layer_end;
   logic [4:0]  o_iter;
   logic        o_busy;
   logic        o_done;

   ldpc_route_scheduler dut (
      .i_clock       (clk),
      .i_reset       (i_reset),
      .i_cfg_we      (i_cfg_we),
      .i_cfg_addr    (i_cfg_addr),
      .i_cfg_data    (i_cfg_data),
      .i_num_entries (i_num_entries),
      .i_num_iters   (i_num_iters),
      .i_start       (i_start),
      .o_ram_addr    (o_ram_addr),
      .o_to_branch   (o_to_branch),
      .o_shift       (o_shift),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_layer_end   (o_layer_end),
      .o_iter        (o_iter),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] ram;
      logic [2:0] br;
      logic [6:0] sh;
      logic       le;
      logic [4:0] iter;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] tbl [256];
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0, done_cyc = 0, busy_cnt = 0, valid_cnt = 0, le_cnt = 0;
   int le_cyc = 0;
   bit le_pend = 0, stall_pend = 0, prev_valid = 0;
   logic [14:0] held;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (i_reset) begin
         le_pend    = 0;
         stall_pend = 0;
         prev_valid = 0;
      end else begin
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_with_layer_end", o_layer_end, 0);
            le_pend = 0;
         end
         if (o_busy) busy_cnt++;
         if (o_layer_end) le_cnt++;
         if (o_valid) valid_cnt++;
         if (o_valid && !prev_valid && le_pend) begin
            chk("drain_gap", cyc - le_cyc, MUX_LAT + 2);
            le_pend = 0;
         end
         if (stall_pend) chk("stall_hold", {o_valid, o_ram_addr, o_to_branch, o_shift}, {1'b1, held});
         if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_cmd: got ram=%0d br=%0d sh=%0d, none expected", o_ram_addr, o_to_branch, o_shift);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("cmd", {o_ram_addr, o_to_branch, o_shift, o_layer_end, o_iter}, e);
            end
         end
         if (o_layer_end) begin
            le_pend = 1;
            le_cyc  = cyc;
         end
         stall_pend = o_valid && !i_ready;
         held       = {o_ram_addr, o_to_branch, o_shift};
         prev_valid = o_valid;
      end
   end

   task automatic write_entry(input int addr, input int ram, input int br, input int sh, input bit last);
      logic [15:0] d;
      d = {ram[4:0], br[2:0], sh[6:0], last};
      tbl[addr]  = d;
      i_cfg_we   = 1'b1;
      i_cfg_addr = addr[7:0];
      i_cfg_data = d;
      @(posedge clk) #1;
      i_cfg_we   = 1'b0;
   endtask

   task automatic push_run(input int ne, input int ni);
      exp_t e;
      logic [15:0] w;
      for (int it = 0; it < ni; it++) begin
         for (int idx = 0; idx < ne; idx++) begin
            w      = tbl[idx];
            e.ram  = w[15:11];
            e.br   = w[10:8];
            e.sh   = w[7:1];
            e.le   = w[0] | (idx == ne - 1);
            e.iter = it[4:0];
            sb.push_back(e);
         end
      end
   endtask

   // exp_lat < 0 skips the latency/busy checks (stalled runs)
   task automatic run(input int ne, input int ni, input bit tog, input bit poke, input int exp_lat, input int exp_le);
      int d0, b0, l0, st, t;
      push_run(ne, ni);
      d0 = done_cnt;
      b0 = busy_cnt;
      l0 = le_cnt;
      i_num_entries = ne[8:0];
      i_num_iters   = ni[4:0];
      i_ready       = 1'b1;
      i_start       = 1'b1;
      st            = cyc;
      @(posedge clk) #1;
      i_start = 1'b0;
      t = 0;
      while (done_cnt == d0 && t < 3000) begin
         if (tog) i_ready = ~i_ready;
         if (poke && t == 4) begin
            i_cfg_we   = 1'b1;
            i_cfg_addr = 8'd0;
            i_cfg_data = 16'hFFFF;
            i_start    = 1'b1;
         end else begin
            i_cfg_we = 1'b0;
            i_start  = 1'b0;
         end
         @(posedge clk) #1;
         t++;
      end
      i_ready  = 1'b1;
      i_cfg_we = 1'b0;
      i_start  = 1'b0;
      if (done_cnt == d0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no o_done, required one within 3000 cycles");
      end else if (exp_lat >= 0) begin
         chk("done_latency", done_cyc - st, exp_lat);
         chk("busy_cycles", busy_cnt - b0, exp_lat);
      end
      repeat (3) @(posedge clk) #1;
      chk("done_once", done_cnt - d0, 1);
      chk("layer_ends", le_cnt - l0, exp_le);
      chk("sb_drained", sb.size(), 0);
      chk("idle_after_done", {o_busy, o_valid}, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, v0, t;
      i_reset = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
      i_num_entries = '0; i_num_iters = '0; i_start = 1'b0; i_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {o_valid, o_layer_end, o_busy, o_done, o_iter, o_ram_addr, o_to_branch, o_shift}, 0);
      i_reset = 1'b0;
      @(posedge clk) #1;

      // two layers of two entries
      write_entry(0, 3, 1, 10, 0);
      write_entry(1, 23, 7, 95, 1);
      write_entry(2, 0, 0, 0, 0);
      write_entry(3, 12, 4, 47, 1);
      run(4, 1, 0, 0, 17, 2);
      run(4, 3, 0, 0, 49, 6);
      chk("final_iter", o_iter, 3);
      // layer end forced by entry count alone at idx2
      run(3, 2, 0, 0, 31, 4);
      run(4, 2, 1, 0, -1, 4);
      run(0, 3, 0, 0, 1, 0);
      run(4, 0, 0, 0, 1, 0);
      // cfg write and start while busy must not disturb the run or the table
      run(4, 2, 0, 1, 33, 4);
      run(4, 1, 0, 0, 17, 2);

      // reset asserted mid-ISSUE
      i_num_entries = 9'd4; i_num_iters = 5'd3; i_start = 1'b1;
      @(posedge clk) #1;
      i_start = 1'b0;
      t = 0;
      while (!o_valid && t < 20) begin
         @(posedge clk) #1;
         t++;
      end
      chk("reached_issue", o_valid, 1);
      i_reset = 1'b1;
      @(posedge clk) #1;
      chk("abort_outputs", {o_valid, o_layer_end, o_busy, o_done, o_iter}, 0);
      i_reset = 1'b0;
      sb.delete();
      d0 = done_cnt;
      repeat (10) @(posedge clk) #1;
      chk("no_done_after_abort", done_cnt - d0, 0);
      run(4, 1, 0, 0, 17, 2);

      // full-depth single layer with field extremes at the last index
      for (int i = 0; i < 256; i++) begin
         if (i == 255) write_entry(i, 23, 7, 95, 0);
         else          write_entry(i, i % 24, i % 8, (i * 7) % 96, 0);
      end
      v0 = valid_cnt;
      run(256, 1, 0, 0, 263, 1);
      chk("back_to_back_valids", valid_cnt - v0, 256);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
